rom_load_arbiter: RTL and testbench



---
 rtl/rgby_pkg.sv | 17 +
 rtl/nib_packer.sv | 56 +++++
 rtl/rom_load_arbiter.sv | 158 +++++++++++++++
 tb/tb_rom_load_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgby_pkg.sv
// Shared constants for the cartridge color load path.
// Color codes, packing ratio and load FSM encoding.
package rgby_pkg;

    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_GREEN  = 2'b01;
    localparam logic [1:0] COLOR_BLUE   = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    localparam int NIBS_PER_WORD = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/nib_packer.sv
// Packs 2-bit colors into a word, first color in the MSBs.
// Exposes the completed word and a left-justified partial word.
module nib_packer
    import rgby_pkg::*;
#(
    parameter int NIBS   = NIBS_PER_WORD,
    parameter int DATA_W = 2 * NIBS,
    parameter int CNT_W  = $clog2(NIBS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [1:0]        color,
    output logic [CNT_W-1:0]  count_next,
    output logic              word_done,
    output logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] flush_word
);

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] acc_shift;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  acc_count;
    logic [CNT_W-1:0]  pad;

    // Accumulate this cycle's color (if any) and derive outputs.
    always_comb begin
        acc_shift  = shift_q;
        acc_count  = count_q;
        if (take) begin
            acc_shift = {shift_q[DATA_W-3:0], color};
            acc_count = count_q + CNT_W'(1);
        end
        word_done  = take && (acc_count == CNT_W'(NIBS));
        word       = acc_shift;
        pad        = CNT_W'(NIBS) - acc_count;
        flush_word = acc_shift << {pad, 1'b0};
        count_next = acc_count;
        if (clear || word_done) begin
            count_next = '0;
        end
    end

    // Shift register and nib count; a full word restarts packing.
    always_ff @(posedge clk) begin
        if (reset || clear || word_done) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= acc_shift;
            count_q <= acc_count;
        end
    end

endmodule

// File: rtl/rom_load_arbiter.sv
// Shares the program RAM between cartridge loading and CPU fetch.
// Writes packed color words while loading, else passes cpu_addr.
module rom_load_arbiter
    import rgby_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int NIBS_PER_WORD = rgby_pkg::NIBS_PER_WORD,
    parameter int DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_done,
    input  logic              color_valid,
    input  logic [1:0]        color,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              cpu_run,
    output logic              rom_valid,
    output logic              loading,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overflow,
    output logic              load_complete
);

    localparam int CNT_W = $clog2(NIBS_PER_WORD + 1);
    localparam logic [ADDR_W+1:0] CAP =
        (ADDR_W+2)'(1) << ADDR_W;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] waddr;
    logic              take;
    logic              clear;
    logic              restart;
    logic              word_done;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] flush_word;
    logic              wr_req;
    logic [DATA_W-1:0] wr_word;
    logic [ADDR_W+1:0] wl_eff;
    logic              full;
    logic              enter_done;

    nib_packer #(
        .NIBS   (NIBS_PER_WORD),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .take       (take),
        .color      (color),
        .count_next (count_next),
        .word_done  (word_done),
        .word       (word),
        .flush_word (flush_word)
    );

    // Load FSM next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load_start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end else if (load_done) begin
                    if (count_next == '0) state_next = ST_DONE;
                    else                  state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (load_start) state_next = ST_LOAD;
                else            state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Packer control, write request and RAM-full detection.
    always_comb begin
        restart = load_start && (state != ST_DONE);
        take    = (state == ST_LOAD) && color_valid && !load_start;
        clear   = (state != ST_LOAD) || load_start;
        wr_req  = 1'b0;
        wr_word = '0;
        if ((state == ST_LOAD) && !load_start) begin
            if (word_done) begin
                wr_req  = 1'b1;
                wr_word = word;
            end else if (load_done && (count_next != '0)) begin
                wr_req  = 1'b1;
                wr_word = flush_word;
            end
        end
        // A write in flight has not yet bumped words_loaded.
        wl_eff     = {1'b0, words_loaded} + (ADDR_W+2)'(ram_we);
        full       = (wl_eff == CAP);
        enter_done = (state_next == ST_DONE) && (state != ST_DONE);
    end

    // Registered FSM state, write strobe, counters and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            waddr         <= '0;
            words_loaded  <= '0;
            ram_we        <= 1'b0;
            ram_din       <= '0;
            rom_valid     <= 1'b0;
            loading       <= 1'b0;
            overflow      <= 1'b0;
            load_complete <= 1'b0;
        end else begin
            state         <= state_next;
            loading       <= (state_next != ST_IDLE);
            ram_we        <= 1'b0;
            load_complete <= 1'b0;
            if (ram_we) begin
                waddr        <= waddr + ADDR_W'(1);
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
            if (wr_req) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    ram_we  <= 1'b1;
                    ram_din <= wr_word;
                end
            end
            if (enter_done) begin
                load_complete <= 1'b1;
                rom_valid     <= 1'b1;
            end
            if (restart) begin
                waddr        <= '0;
                words_loaded <= '0;
                overflow     <= 1'b0;
                rom_valid    <= 1'b0;
            end
        end
    end

    // Address port mux and CPU run permission.
    always_comb begin
        ram_addr = (state == ST_IDLE) ? cpu_addr : waddr;
        cpu_run  = rom_valid && (state == ST_IDLE);
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Bench for rom_load_arbiter: 8-bit and 2-bit address instances
// fed the same stimulus, writes checked against a scoreboard.
module tb_rom_load_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_done;
    logic        color_valid;
    logic [1:0]  color;
    logic [7:0]  cpu_addr;

    logic [7:0]  ram_addr8;
    logic [11:0] ram_din8;
    logic        ram_we8, cpu_run8, rom_valid8, loading8;
    logic [8:0]  wl8;
    logic        ovf8, lc8;

    logic [1:0]  ram_addr2;
    logic [11:0] ram_din2;
    logic        ram_we2, cpu_run2, rom_valid2, loading2;
    logic [2:0]  wl2;
    logic        ovf2, lc2;

    int errors = 0;
    int checks = 0;
    int we8_cnt = 0;
    int we2_cnt = 0;
    int lc8_cnt = 0;

    logic [19:0] q8[$];
    logic [19:0] q2[$];

    logic [11:0] m_shift;
    int          m_count;
    int          m_wl8;
    int          m_wl2;
    bit          m_active;

    always #5 clk = ~clk;

    rom_load_arbiter #(.ADDR_W(8)) u8 (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_done     (load_done),
        .color_valid   (color_valid),
        .color         (color),
        .cpu_addr      (cpu_addr),
        .ram_addr      (ram_addr8),
        .ram_din       (ram_din8),
        .ram_we        (ram_we8),
        .cpu_run       (cpu_run8),
        .rom_valid     (rom_valid8),
        .loading       (loading8),
        .words_loaded  (wl8),
        .overflow      (ovf8),
        .load_complete (lc8)
    );

    rom_load_arbiter #(.ADDR_W(2)) u2 (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_done     (load_done),
        .color_valid   (color_valid),
        .color         (color),
        .cpu_addr      (cpu_addr[1:0]),
        .ram_addr      (ram_addr2),
        .ram_din       (ram_din2),
        .ram_we        (ram_we2),
        .cpu_run       (cpu_run2),
        .rom_valid     (rom_valid2),
        .loading       (loading2),
        .words_loaded  (wl2),
        .overflow      (ovf2),
        .load_complete (lc2)
    );

    // Scoreboard side: every write must match the next expected one.
    always @(negedge clk) begin
        logic [19:0] exp;
        if (ram_we8 === 1'b1) begin
            we8_cnt++;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL wr8_extra got=%h/%h want=none",
                         ram_addr8, ram_din8);
            end else begin
                exp = q8.pop_front();
                if ({ram_addr8, ram_din8} !== exp) begin
                    errors++;
                    $display("FAIL wr8 got=%h want=%h",
                             {ram_addr8, ram_din8}, exp);
                end
            end
        end
        if (ram_we2 === 1'b1) begin
            we2_cnt++;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL wr2_extra got=%h/%h want=none",
                         ram_addr2, ram_din2);
            end else begin
                exp = q2.pop_front();
                if ({6'b0, ram_addr2, ram_din2} !== exp) begin
                    errors++;
                    $display("FAIL wr2 got=%h want=%h",
                             {6'b0, ram_addr2, ram_din2}, exp);
                end
            end
        end
        if (lc8 === 1'b1) lc8_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push_word(input logic [11:0] w);
        if (m_wl8 < 256) begin
            q8.push_back({8'(m_wl8), w});
            m_wl8++;
        end
        if (m_wl2 < 4) begin
            q2.push_back({6'b0, 2'(m_wl2), w});
            m_wl2++;
        end
    endtask

    task automatic model_done();
        if (m_count != 0)
            push_word(m_shift << (2 * (6 - m_count)));
        m_shift  = '0;
        m_count  = 0;
        m_active = 0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        m_shift  = '0;
        m_count  = 0;
        m_wl8    = 0;
        m_wl2    = 0;
        m_active = 1;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [1:0] c, input bit done);
        color_valid = 1'b1;
        color       = c;
        load_done   = done;
        if (m_active) begin
            m_shift = {m_shift[9:0], c};
            m_count++;
            if (m_count == 6) begin
                push_word(m_shift);
                m_shift = '0;
                m_count = 0;
            end
            if (done) model_done();
        end
        cyc();
        color_valid = 1'b0;
        load_done   = 1'b0;
    endtask

    task automatic done_only();
        load_done = 1'b1;
        if (m_active) model_done();
        cyc();
        load_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if ({ram_we8, rom_valid8, loading8, ovf8, lc8, cpu_run8}
            !== 6'b0) begin
            errors++;
            $display("FAIL rst_flags got=%b want=000000",
                     {ram_we8, rom_valid8, loading8,
                      ovf8, lc8, cpu_run8});
        end
        checks++;
        if ({wl8, ram_din8} !== 21'h0) begin
            errors++;
            $display("FAIL rst_regs got=%h/%h want=0/0",
                     wl8, ram_din8);
        end
        reset = 1'b0;
        cyc();
        cpu_addr = 8'h5C;
        #1;
        checks++;
        if (ram_addr8 !== 8'h5C) begin
            errors++;
            $display("FAIL idle_addr got=%h want=5c", ram_addr8);
        end
    endtask

    task automatic test_word();
        logic [1:0] cs[6];
        cs = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        start_load();
        for (int i = 0; i < 6; i++) send(cs[i], 0);
        checks++;
        if ({ram_we8, ram_addr8, ram_din8} !== {1'b1, 8'h00, 12'hC6F})
        begin
            errors++;
            $display("FAIL word1 got=%b/%h/%h want=1/00/c6f",
                     ram_we8, ram_addr8, ram_din8);
        end
        idle(1);
        checks++;
        if (wl8 !== 9'd1) begin
            errors++;
            $display("FAIL word1_cnt got=%0d want=1", wl8);
        end
    endtask

    task automatic test_flush();
        int lc0;
        lc0 = lc8_cnt;
        send(2'd2, 0);
        send(2'd1, 0);
        done_only();
        idle(4);
        checks++;
        if ({rom_valid8, cpu_run8, loading8} !== 3'b110) begin
            errors++;
            $display("FAIL flush_stat got=%b want=110",
                     {rom_valid8, cpu_run8, loading8});
        end
        checks++;
        if (lc8_cnt - lc0 !== 1 || q8.size() !== 0) begin
            errors++;
            $display("FAIL flush_done got=%0d/%0d want=1/0",
                     lc8_cnt - lc0, q8.size());
        end
        checks++;
        if (wl8 !== 9'd2) begin
            errors++;
            $display("FAIL flush_cnt got=%0d want=2", wl8);
        end
        cpu_addr = 8'h2A;
        #1;
        checks++;
        if (ram_addr8 !== 8'h2A) begin
            errors++;
            $display("FAIL cpu_addr got=%h want=2a", ram_addr8);
        end
    endtask

    task automatic test_done_with_color();
        int we0, lc0;
        start_load();
        we0 = we8_cnt;
        lc0 = lc8_cnt;
        for (int i = 0; i < 5; i++) send(2'(i), 0);
        send(2'd3, 1);
        idle(4);
        checks++;
        if (we8_cnt - we0 !== 1 || lc8_cnt - lc0 !== 1) begin
            errors++;
            $display("FAIL sixth_done got=%0d/%0d want=1/1",
                     we8_cnt - we0, lc8_cnt - lc0);
        end
        checks++;
        if ({wl8, rom_valid8, q8.size() == 0} !== {9'd1, 2'b11}) begin
            errors++;
            $display("FAIL sixth_stat got=%0d/%b want=1/1",
                     wl8, rom_valid8);
        end
        start_load();
        we0 = we8_cnt;
        send(2'd1, 0);
        send(2'd2, 1);
        idle(4);
        checks++;
        if (we8_cnt - we0 !== 1 || q8.size() !== 0
            || wl8 !== 9'd1) begin
            errors++;
            $display("FAIL part_done got=%0d/%0d/%0d want=1/0/1",
                     we8_cnt - we0, q8.size(), wl8);
        end
    endtask

    task automatic test_overflow();
        int we0;
        start_load();
        we0 = we2_cnt;
        for (int i = 0; i < 30; i++)
            send(2'($urandom_range(0, 3)), 0);
        done_only();
        idle(4);
        checks++;
        if (we2_cnt - we0 !== 4 || q2.size() !== 0) begin
            errors++;
            $display("FAIL ovf_writes got=%0d/%0d want=4/0",
                     we2_cnt - we0, q2.size());
        end
        checks++;
        if ({wl2, ovf2} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL ovf2 got=%0d/%b want=4/1", wl2, ovf2);
        end
        checks++;
        if ({wl8, ovf8, q8.size() == 0} !== {9'd5, 2'b01}) begin
            errors++;
            $display("FAIL ovf8 got=%0d/%b want=5/0", wl8, ovf8);
        end
        start_load();
        checks++;
        if ({wl2, ovf2} !== 4'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%0d/%b want=0/0", wl2, ovf2);
        end
        done_only();
        idle(3);
    endtask

    task automatic test_reset_mid();
        int we0;
        we0 = we8_cnt;
        start_load();
        for (int i = 0; i < 3; i++) send(2'd3, 0);
        reset = 1'b1;
        cyc();
        checks++;
        if ({ram_we8, rom_valid8, cpu_run8, loading8, ovf8, lc8,
             wl8, ram_din8} !== 27'h0) begin
            errors++;
            $display("FAIL rst_mid got=%b/%0d/%h want=0/0/0",
                     {ram_we8, rom_valid8, cpu_run8,
                      loading8, ovf8, lc8}, wl8, ram_din8);
        end
        reset    = 1'b0;
        m_active = 0;
        m_shift  = '0;
        m_count  = 0;
        send(2'd2, 0);
        idle(3);
        checks++;
        if (we8_cnt - we0 !== 0 || wl8 !== 9'd0
            || loading8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_color got=%0d/%0d/%b want=0/0/0",
                     we8_cnt - we0, wl8, loading8);
        end
    endtask

    task automatic test_restart();
        start_load();
        for (int i = 0; i < 12; i++) send(2'(i % 4), 0);
        idle(2);
        checks++;
        if (wl8 !== 9'd2) begin
            errors++;
            $display("FAIL pre_restart got=%0d want=2", wl8);
        end
        start_load();
        checks++;
        if ({ram_addr8, wl8, rom_valid8, loading8}
            !== {8'h00, 9'd0, 2'b01}) begin
            errors++;
            $display("FAIL restart got=%h/%0d/%b want=00/0/0",
                     ram_addr8, wl8, rom_valid8);
        end
        for (int i = 0; i < 6; i++) send(2'd1, 0);
        idle(1);
        checks++;
        if (rom_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got=%b want=0", rom_valid8);
        end
        done_only();
        idle(4);
        checks++;
        if ({rom_valid8, wl8, q8.size() == 0}
            !== {1'b1, 9'd1, 1'b1}) begin
            errors++;
            $display("FAIL restart_end got=%b/%0d want=1/1",
                     rom_valid8, wl8);
        end
    endtask

    initial begin
        reset       = 1'b1;
        load_start  = 1'b0;
        load_done   = 1'b0;
        color_valid = 1'b0;
        color       = 2'd0;
        cpu_addr    = 8'h00;
        m_shift     = '0;
        m_count     = 0;
        m_wl8       = 0;
        m_wl2       = 0;
        m_active    = 0;
        test_reset();
        test_word();
        test_flush();
        test_done_with_color();
        test_overflow();
        test_reset_mid();
        test_restart();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
